if_fetch: RTL and testbench

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch_if.sv | 11 +
 rtl/if_fetch.sv | 95 +++++++++
 tb/tb_if_fetch.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_if.sv
// Instruction-memory request/response bus: one request per gnt, data returned on rvalid.
interface if_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch with one outstanding imem request; instruction shows on if_valid the cycle after rvalid.
// Min 3 cycles per instruction; stall holds the presented instruction, redirect overrides everything.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  if_fetch_if.master         imem,
  output logic               if_valid,
  output logic [31:0]        if_pc_current,
  output logic [31:0]        if_im_inst,
  output logic [31:0]        if_pc_next
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    DROP = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic        capture;
  logic [31:0] redir_pc;
  logic        unused_redir_bits;

  assign redir_pc          = {redirect_pc[31:2], 2'b00};
  assign unused_redir_bits = ^redirect_pc[1:0];
  assign imem.addr         = pc;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    capture   = 1'b0;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (imem.gnt) state_nxt = redirect ? DROP : WAIT;
      end
      WAIT: begin
        if (imem.rvalid) begin
          if (redirect) begin
            state_nxt = REQ;
          end else begin
            state_nxt = HOLD;
            capture   = 1'b1;
          end
        end else if (redirect) begin
          state_nxt = DROP;
        end
      end
      HOLD: begin
        if (redirect || !stall) state_nxt = REQ;
        if (!redirect && !stall) pc_nxt = pc + 32'd4;
      end
      // Draining a response whose request was superseded; rvalid frees the single slot.
      DROP: begin
        if (imem.rvalid) state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase
    if (redirect) pc_nxt = redir_pc;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      pc            <= {RESET_PC[31:2], 2'b00};
      imem.req      <= 1'b0;
      if_valid      <= 1'b0;
      if_pc_current <= 32'd0;
      if_im_inst    <= 32'd0;
      if_pc_next    <= 32'd0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      imem.req <= (state_nxt == REQ);
      // HOLD is the only state in which a live instruction is presented.
      if_valid <= (state_nxt == HOLD);
      if (capture) begin
        if_pc_current <= pc;
        if_im_inst    <= imem.rdata;
        if_pc_next    <= pc + 32'd4;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: table-driven fetch stream with scoreboard plus redirect/reset corner sequences.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        if_valid;
  logic [31:0] if_pc_current;
  logic [31:0] if_im_inst;
  logic [31:0] if_pc_next;

  if_fetch_if bus ();

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .imem          (bus),
    .if_valid      (if_valid),
    .if_pc_current (if_pc_current),
    .if_im_inst    (if_im_inst),
    .if_pc_next    (if_pc_next)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] pcn;
  } exp_t;

  typedef struct {
    int          gw;
    int          rw;
    int          st;
    logic [31:0] addr;
    logic [31:0] inst;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[5];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one fetch: waits for the request, grants after gw cycles, returns data after rw cycles,
  // then stalls st cycles (with a stray rvalid) and releases unless keep is set.
  task automatic do_fetch(input int gw, input int rw, input int st,
                          input logic [31:0] addr, input logic [31:0] inst, input bit keep);
    int   n = 0;
    exp_t e;
    while (bus.req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("req_seen", {31'd0, bus.req}, 32'd1);
    if (bus.req !== 1'b1) return;
    chk("req_addr", bus.addr, addr);
    bus.gnt = 1'b0;
    for (int i = 0; i < gw; i++) begin
      tick();
      chk("req_hold", {31'd0, bus.req}, 32'd1);
      chk("addr_stable", bus.addr, addr);
    end
    bus.gnt = 1'b1;
    e.pc = addr;
    e.inst = inst;
    e.pcn = addr + 32'd4;
    sbq.push_back(e);
    tick();
    bus.gnt = 1'b0;
    chk("wait_noreq", {31'd0, bus.req}, 32'd0);
    for (int i = 0; i < rw; i++) begin
      tick();
      chk("wait_novalid", {31'd0, if_valid}, 32'd0);
    end
    bus.rvalid = 1'b1;
    bus.rdata = inst;
    tick();
    bus.rvalid = 1'b0;
    chk("valid", {31'd0, if_valid}, 32'd1);
    if (sbq.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_pop: got empty want entry");
    end else begin
      e = sbq.pop_front();
      chk("pc_cur", if_pc_current, e.pc);
      chk("inst", if_im_inst, e.inst);
      chk("pc_next", if_pc_next, e.pcn);
    end
    stall = 1'b1;
    bus.rvalid = 1'b1;
    bus.rdata = 32'hBAD0_0000 ^ addr;
    for (int i = 0; i < st; i++) begin
      tick();
      chk("hold_valid", {31'd0, if_valid}, 32'd1);
      chk("hold_inst", if_im_inst, inst);
      chk("hold_pc", if_pc_current, addr);
      chk("hold_noreq", {31'd0, bus.req}, 32'd0);
    end
    bus.rvalid = 1'b0;
    if (!keep) begin
      stall = 1'b0;
      tick();
      chk("hold_release", {31'd0, if_valid}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 0, 0, 32'h0000_0000, 32'h0000_0013};
    tbl[1] = '{3, 0, 4, 32'h0000_0004, 32'h0010_0093};
    tbl[2] = '{0, 2, 0, 32'h0000_0008, 32'h0020_0113};
    tbl[3] = '{1, 1, 1, 32'h0000_000C, 32'h0030_0193};
    tbl[4] = '{2, 0, 2, 32'h0000_0010, 32'h0040_0213};

    bus.gnt = 1'b0;
    bus.rvalid = 1'b0;
    bus.rdata = 32'd0;

    // Reset state
    tick();
    tick();
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_req", {31'd0, bus.req}, 32'd0);
    chk("rst_pc_cur", if_pc_current, 32'd0);
    chk("rst_inst", if_im_inst, 32'd0);
    chk("rst_pc_next", if_pc_next, 32'd0);
    rstn = 1'b1;
    chk("idle_noreq", {31'd0, bus.req}, 32'd0);
    tick();
    chk("first_req", {31'd0, bus.req}, 32'd1);
    chk("first_addr", bus.addr, 32'h0000_0000);

    for (int i = 0; i < 5; i++)
      do_fetch(tbl[i].gw, tbl[i].rw, tbl[i].st, tbl[i].addr, tbl[i].inst, 1'b0);

    // Redirect while waiting; late response must be swallowed
    bus.gnt = 1'b1;
    tick();
    bus.gnt = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    chk("drop_noreq", {31'd0, bus.req}, 32'd0);
    chk("drop_valid", {31'd0, if_valid}, 32'd0);
    bus.rvalid = 1'b1;
    bus.rdata = 32'hDEAD_BEEF;
    tick();
    bus.rvalid = 1'b0;
    chk("drop_inst", if_im_inst, 32'h0040_0213);
    chk("drop_valid2", {31'd0, if_valid}, 32'd0);
    chk("redir_req", {31'd0, bus.req}, 32'd1);
    chk("redir_addr", bus.addr, 32'h0000_0100);
    tick();
    chk("drop_inst2", if_im_inst, 32'h0040_0213);

    // Redirect and stall together in HOLD
    do_fetch(0, 0, 1, 32'h0000_0100, 32'h0050_0293, 1'b1);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    stall = 1'b0;
    chk("rs_valid", {31'd0, if_valid}, 32'd0);
    chk("rs_req", {31'd0, bus.req}, 32'd1);
    chk("rs_addr", bus.addr, 32'h0000_0200);

    // Redirect coinciding with rvalid in WAIT
    bus.gnt = 1'b1;
    tick();
    bus.gnt = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0040;
    bus.rvalid = 1'b1;
    bus.rdata = 32'hCAFE_F00D;
    tick();
    redirect = 1'b0;
    bus.rvalid = 1'b0;
    chk("wr_valid", {31'd0, if_valid}, 32'd0);
    chk("wr_req", {31'd0, bus.req}, 32'd1);
    chk("wr_addr", bus.addr, 32'h0000_0040);
    chk("wr_inst", if_im_inst, 32'h0050_0293);

    // PC wrap at the top of the address space
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    chk("wrap_req_addr", bus.addr, 32'hFFFF_FFFC);
    do_fetch(0, 1, 0, 32'hFFFF_FFFC, 32'h0060_0313, 1'b1);
    chk("wrap_pc_next", if_pc_next, 32'h0000_0000);
    stall = 1'b0;
    tick();
    chk("wrap_addr", bus.addr, 32'h0000_0000);
    chk("wrap_req", {31'd0, bus.req}, 32'd1);

    // Reset in WAIT, stray rvalid after release
    bus.gnt = 1'b1;
    tick();
    bus.gnt = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    chk("mrst_req", {31'd0, bus.req}, 32'd0);
    chk("mrst_valid", {31'd0, if_valid}, 32'd0);
    chk("mrst_inst", if_im_inst, 32'd0);
    chk("mrst_pc_next", if_pc_next, 32'd0);
    tick();
    rstn = 1'b1;
    bus.rvalid = 1'b1;
    bus.rdata = 32'hDEAD_BEEF;
    tick();
    chk("stray_req", {31'd0, bus.req}, 32'd1);
    chk("stray_addr", bus.addr, 32'h0000_0000);
    chk("stray_valid", {31'd0, if_valid}, 32'd0);
    tick();
    bus.rvalid = 1'b0;
    chk("stray_valid2", {31'd0, if_valid}, 32'd0);
    chk("stray_inst", if_im_inst, 32'd0);
    do_fetch(0, 0, 0, 32'h0000_0000, 32'h0070_0393, 1'b0);

    chk("sb_empty", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
